// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: sequencer state codes,
// program geometry and instruction field layout.
package instr_fetch_unit_pkg;

    localparam int MAX_PC = 7;
    localparam int DEPTH  = MAX_PC + 1;
    localparam int CMD_W  = 6;
    localparam int ADDR_W = 3;
    localparam int PC_W   = 4;
    localparam int CNT_W  = 4;

    localparam int         OP_HI       = 5;
    localparam int         OP_LO       = 4;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    typedef enum logic [2:0] {
        ST_INPUT   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_RF      = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_RW      = 3'd4,
        ST_DISPLAY = 3'd5
    } seq_state_e;

    function automatic logic is_reserved(input logic [CMD_W-1:0] cmd);
        return cmd[OP_HI:OP_LO] == OP_RESERVED;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Sequencer-to-fetch-unit bundle; the fetch unit is the slave (responder).
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [2:0]        current_state;
    logic              done;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [CMD_W-1:0]  load_data;
    logic [CMD_W-1:0]  command;
    logic [PC_W-1:0]   PC;
    logic              instruction_invalid;
    logic [CNT_W-1:0]  invalid_count;
    logic              halted;

    modport master (
        output current_state, done, load_en, load_addr, load_data,
        input  command, PC, instruction_invalid, invalid_count, halted
    );

    modport slave (
        input  current_state, done, load_en, load_addr, load_data,
        output command, PC, instruction_invalid, invalid_count, halted
    );

endinterface

// File: rtl/instr_fetch_unit_prog_buffer.sv
// Program storage with per-entry valid bits; combinational read so a fetch
// latched on a write edge naturally sees the pre-write contents.
module prog_buffer
    import instr_fetch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [CMD_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [CMD_W-1:0]  rdata_o,
    output logic              rvalid_o
);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Only the valid bits are reset; stale data stays in the array.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
        if (we_i && !reset) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: latches the instruction at PC during INPUT, advances PC on RW,
// counts invalid fetches and reports the DISPLAY (halted) condition.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.slave    bus
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             inv_q, inv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;

    logic             buf_we;
    logic [CMD_W-1:0] rd_data;
    logic             rd_valid;

    assign buf_we = bus.load_en && (bus.current_state == ST_INPUT) && !reset;

    prog_buffer u_prog_buffer (
        .clk      (clk),
        .reset    (reset),
        .we_i     (buf_we),
        .waddr_i  (bus.load_addr),
        .wdata_i  (bus.load_data),
        .raddr_i  (pc_q[ADDR_W-1:0]),
        .rdata_o  (rd_data),
        .rvalid_o (rd_valid)
    );

    // Codes 6 and 7 fall through to the default and hold everything.
    always_comb begin
        pc_d     = pc_q;
        cmd_d    = cmd_q;
        inv_d    = inv_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        case (bus.current_state)
            ST_INPUT: begin
                halted_d = 1'b0;
                cmd_d    = rd_data;
                inv_d    = ~rd_valid | is_reserved(rd_data);
                if (inv_d && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE, ST_RF, ST_EXECUTE: begin
                halted_d = 1'b0;
            end
            ST_RW: begin
                halted_d = 1'b0;
                if (pc_q < PC_W'(MAX_PC)) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_DISPLAY: begin
                halted_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            cmd_q    <= '0;
            inv_q    <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cmd_q    <= cmd_d;
            inv_q    <= inv_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign bus.command             = cmd_q;
    assign bus.PC                  = pc_q;
    assign bus.instruction_invalid = inv_q;
    assign bus.invalid_count       = cnt_q;
    assign bus.halted              = halted_q;

`ifndef SYNTHESIS
    // done may only rise while the sequencer idles in INPUT or DISPLAY.
    a_done_protocol: assert property (@(posedge clk) disable iff (reset)
        $rose(bus.done) |-> (bus.current_state == ST_INPUT ||
                             bus.current_state == ST_DISPLAY))
        else $error("done rose in state %0d", bus.current_state);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected outputs into
// a queue, a negedge monitor pops and compares them against the DUT.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    typedef struct packed {
        logic [5:0] cmd;
        logic       cmd_chk;
        logic [3:0] pc;
        logic       inv;
        logic [3:0] cnt;
        logic       halt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t  exp_q[$];
    string name_q[$];

    instr_fetch_unit_if ifc ();

    instr_fetch_unit dut (
        .clk   (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ((e.cmd_chk && ifc.command !== e.cmd) || ifc.PC !== e.pc ||
                ifc.instruction_invalid !== e.inv || ifc.invalid_count !== e.cnt ||
                ifc.halted !== e.halt) begin
                failures++;
                $display("FAIL %s: got cmd=%b pc=%0d inv=%b cnt=%0d halt=%b, want cmd=%b(chk=%b) pc=%0d inv=%b cnt=%0d halt=%b",
                         n, ifc.command, ifc.PC, ifc.instruction_invalid, ifc.invalid_count,
                         ifc.halted, e.cmd, e.cmd_chk, e.pc, e.inv, e.cnt, e.halt);
            end
        end
    end

    task automatic drive(input logic [2:0] st, input logic le,
                         input logic [2:0] la, input logic [5:0] ld);
        ifc.current_state = st;
        ifc.load_en       = le;
        ifc.load_addr     = la;
        ifc.load_data     = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string n, input logic [5:0] c, input logic cc,
                              input logic [3:0] p, input logic i,
                              input logic [3:0] k, input logic h);
        exp_t e;
        e = '{cmd: c, cmd_chk: cc, pc: p, inv: i, cnt: k, halt: h};
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic run_instr(input logic [3:0] pc, input logic [5:0] cmd, input logic cc,
                             input logic inv, input logic [3:0] cnt, input logic [3:0] pc_next);
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("fetch", cmd, cc, pc, inv, cnt, 1'b0);
        drive(ST_DECODE, 1'b0, 3'd0, 6'd0);
        drive(ST_RF, 1'b0, 3'd0, 6'd0);
        drive(ST_EXECUTE, 1'b0, 3'd0, 6'd0);
        expect_out("hold_exec", cmd, cc, pc, inv, cnt, 1'b0);
        drive(ST_RW, 1'b0, 3'd0, 6'd0);
        expect_out("leave_rw", cmd, cc, pc_next, inv, cnt, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        ifc.done = 1'b0;
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("reset", 6'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        drive(ST_INPUT, 1'b1, 3'd0, 6'b111111);
        expect_out("reset_blocks_load", 6'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;

        // First load collides with the fetch of PC 0: old (unloaded) entry seen.
        drive(ST_INPUT, 1'b1, 3'd0, 6'b000110);
        expect_out("rbw_unloaded", 6'd0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
        drive(ST_INPUT, 1'b1, 3'd1, 6'b010110);
        expect_out("fetch_new_data", 6'b000110, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
        drive(ST_INPUT, 1'b1, 3'd2, 6'b110001);
        drive(ST_INPUT, 1'b1, 3'd3, 6'b011011);
        drive(ST_INPUT, 1'b1, 3'd4, 6'b100111);
        drive(ST_INPUT, 1'b1, 3'd6, 6'b001001);
        drive(ST_INPUT, 1'b1, 3'd7, 6'b101110);
        expect_out("load_done", 6'b000110, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);

        drive(ST_DECODE, 1'b0, 3'd0, 6'd0);
        expect_out("first_decode", 6'b000110, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
        drive(ST_RF, 1'b0, 3'd0, 6'd0);
        drive(ST_EXECUTE, 1'b1, 3'd0, 6'b111111);
        drive(ST_RW, 1'b0, 3'd0, 6'd0);
        expect_out("pc0_rw", 6'b000110, 1'b1, 4'd1, 1'b0, 4'd1, 1'b0);

        run_instr(4'd1, 6'b010110, 1'b1, 1'b0, 4'd1, 4'd2);
        run_instr(4'd2, 6'b110001, 1'b1, 1'b1, 4'd2, 4'd3);
        run_instr(4'd3, 6'b011011, 1'b1, 1'b0, 4'd2, 4'd4);

        drive(ST_INPUT, 1'b1, 3'd4, 6'b000011);
        expect_out("rbw_old", 6'b100111, 1'b1, 4'd4, 1'b0, 4'd2, 1'b0);
        drive(ST_DECODE, 1'b0, 3'd0, 6'd0);
        drive(ST_RF, 1'b0, 3'd0, 6'd0);
        drive(ST_EXECUTE, 1'b0, 3'd0, 6'd0);
        drive(ST_RW, 1'b0, 3'd0, 6'd0);
        expect_out("pc4_rw", 6'b100111, 1'b1, 4'd5, 1'b0, 4'd2, 1'b0);

        run_instr(4'd5, 6'd0, 1'b0, 1'b1, 4'd3, 4'd6);
        run_instr(4'd6, 6'b001001, 1'b1, 1'b0, 4'd3, 4'd7);
        run_instr(4'd7, 6'b101110, 1'b1, 1'b0, 4'd3, 4'd7);

        ifc.done = 1'b1;
        drive(ST_DISPLAY, 1'b1, 3'd7, 6'b111111);
        expect_out("display_halt", 6'b101110, 1'b1, 4'd7, 1'b0, 4'd3, 1'b1);
        drive(ST_DISPLAY, 1'b0, 3'd0, 6'd0);
        expect_out("display_hold", 6'b101110, 1'b1, 4'd7, 1'b0, 4'd3, 1'b1);
        ifc.done = 1'b0;
        drive(3'd6, 1'b1, 3'd7, 6'b111111);
        expect_out("unknown_state", 6'b101110, 1'b1, 4'd7, 1'b0, 4'd3, 1'b1);
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("display_load_ignored", 6'b101110, 1'b1, 4'd7, 1'b0, 4'd3, 1'b0);

        rst = 1'b1;
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("reset2", 6'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        drive(ST_INPUT, 1'b1, 3'd0, 6'b000110);
        expect_out("valid_cleared", 6'b000110, 1'b1, 4'd0, 1'b1, 4'd1, 1'b0);
        drive(ST_INPUT, 1'b1, 3'd1, 6'b010110);
        drive(ST_INPUT, 1'b1, 3'd2, 6'b110001);
        drive(ST_INPUT, 1'b1, 3'd3, 6'b011011);
        expect_out("reload", 6'b000110, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0);
        run_instr(4'd0, 6'b000110, 1'b1, 1'b0, 4'd1, 4'd1);
        run_instr(4'd1, 6'b010110, 1'b1, 1'b0, 4'd1, 4'd2);
        run_instr(4'd2, 6'b110001, 1'b1, 1'b1, 4'd2, 4'd3);
        run_instr(4'd3, 6'b011011, 1'b1, 1'b0, 4'd2, 4'd4);
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("stale_unloaded", 6'b000011, 1'b1, 4'd4, 1'b1, 4'd3, 1'b0);
        drive(ST_DECODE, 1'b0, 3'd0, 6'd0);
        drive(ST_RF, 1'b0, 3'd0, 6'd0);
        expect_out("pre_reset_mid", 6'b000011, 1'b1, 4'd4, 1'b1, 4'd3, 1'b0);
        rst = 1'b1;
        drive(ST_EXECUTE, 1'b0, 3'd0, 6'd0);
        expect_out("reset_mid", 6'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
        expect_out("post_reset_fetch", 6'b000110, 1'b1, 4'd0, 1'b1, 4'd1, 1'b0);

        // Repeated invalid fetches at PC 0 drive the counter into saturation.
        for (int i = 2; i <= 17; i++) begin
            drive(ST_INPUT, 1'b0, 3'd0, 6'd0);
            expect_out("cnt_sat", 6'b000110, 1'b1, 4'd0, 1'b1,
                       (i > 15) ? 4'd15 : 4'(i), 1'b0);
        end

        drive(ST_DECODE, 1'b0, 3'd0, 6'd0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
